// File: rtl/alu_exec_if.sv
// Handshake bundle between the issue stage and the ALU execute unit.
// The master modport is the upstream/downstream side; the slave modport is the unit itself.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output flush, in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  flush, in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle ADD/SUB/AND/OR/SLT, serial SLL, and a result
// register held until the downstream stage accepts it.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic       clk,
    input logic       rst_n,
    alu_exec_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               illegal_q;

    logic [WIDTH-1:0]   alu_value;
    logic               alu_illegal;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   acc_next;
    logic               start_shift;

    assign shamt    = bus.src_b[SHAMT_W-1:0];
    assign acc_next = acc << 1;

    // SLL with a zero shift amount completes like a single-cycle op, so it is
    // folded into the combinational result as a pass-through of src_a.
    assign start_shift = (bus.alu_ctrl == 3'b100) && (shamt != '0);

    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        case (bus.alu_ctrl)
            3'b000:  alu_value = bus.src_a + bus.src_b;
            3'b001:  alu_value = bus.src_a - bus.src_b;
            3'b010:  alu_value = bus.src_a & bus.src_b;
            3'b011:  alu_value = bus.src_a | bus.src_b;
            3'b101:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            3'b100:  alu_value = bus.src_a;
            default: alu_illegal = 1'b1;
        endcase
    end

    // Flush takes priority over every state, including an accept in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (bus.flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (start_shift) begin
                            acc   <= bus.src_a;
                            cnt   <= shamt;
                            state <= SHIFT;
                        end else begin
                            result_q  <= alu_value;
                            zero_q    <= (alu_value == '0);
                            illegal_q <= alu_illegal;
                            state     <= HOLD;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        result_q  <= acc_next;
                        zero_q    <= (acc_next == '0);
                        illegal_q <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

endmodule
